// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL lock qualifier / reset sequencer.
// Counter-width helper keeps per-phase counters minimal.
package pll_rst_pkg;

  localparam int MIN_SYNC = 2;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    LOST,
    PLL_RST
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_rst_seq_lock_sync.sv
// Multi-flop synchroniser bringing the async PLL lock into clk.
// Stage count is clamped to the safe minimum.
module lock_sync
  import pll_rst_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_i,
  output logic lock_s
);

  localparam int N = (STAGES < MIN_SYNC) ? MIN_SYNC : STAGES;

  (* ASYNC_REG = "TRUE" *)
  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], lock_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign lock_s = sync_q[N-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Qualifies PLL lock, then releases sys_rst/ready; counts lock loss.
// PLL_LOCK_TIMEOUT_EN adds a timed pll_rst retry pulse from WAIT_LOCK.
module pll_lock_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int PLL_RST_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock,
  input  logic             clr_lost,
  output logic             sys_rst,
  output logic             ready,
  output logic             pll_rst,
  output logic             lost_sticky,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int STAB_W = cnt_w(STABLE_CYCLES);
  localparam int HOLD_W = cnt_w(RST_HOLD_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST =
    STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RST_HOLD_CYCLES - 1);

  logic lock_s;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .rst    (rst),
    .lock_i (lock),
    .lock_s (lock_s)
  );

  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
  logic              sticky_q, sticky_d;
  logic              sys_rst_q, sys_rst_d;
  logic              ready_q, ready_d;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TMO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int PRST_W = cnt_w(PLL_RST_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PRST_W-1:0] PRST_LAST =
    PRST_W'(PLL_RST_CYCLES - 1);

  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [PRST_W-1:0] prst_cnt_q, prst_cnt_d;
  logic [CNT_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic              pll_rst_q, pll_rst_d;
`endif

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    hold_cnt_d = hold_cnt_q;
    loss_cnt_d = loss_cnt_q;
    sticky_d   = sticky_q & ~clr_lost;
`ifdef PLL_LOCK_TIMEOUT_EN
    prst_cnt_d  = prst_cnt_q;
    retry_cnt_d = retry_cnt_q;
`endif

    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = STABLE;
          stab_cnt_d = '0;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = PLL_RST;
          prst_cnt_d  = '0;
          retry_cnt_d = (retry_cnt_q == '1) ?
                        retry_cnt_q : retry_cnt_q + 1'b1;
        end
`endif
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = RELEASE;
          hold_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = LOST;
          sticky_d   = 1'b1;
          loss_cnt_d = (loss_cnt_q == '1) ?
                       loss_cnt_q : loss_cnt_q + 1'b1;
        end
      end
      LOST: begin
        state_d = WAIT_LOCK;
      end
`ifdef PLL_LOCK_TIMEOUT_EN
      PLL_RST: begin
        // lock_s is deliberately ignored while the PLL is held in reset
        if (prst_cnt_q == PRST_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          prst_cnt_d = prst_cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

`ifdef PLL_LOCK_TIMEOUT_EN
    tmo_cnt_d = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ?
                tmo_cnt_q + 1'b1 : '0;
    pll_rst_d = (state_d == PLL_RST);
`endif
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      loss_cnt_q  <= '0;
      sticky_q    <= 1'b0;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      sticky_q    <= sticky_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      prst_cnt_q  <= '0;
      retry_cnt_q <= '0;
      pll_rst_q   <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      prst_cnt_q  <= prst_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      pll_rst_q   <= pll_rst_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign retry_cnt = retry_cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, PLL_RST_CYCLES};
  assign pll_rst    = 1'b0;
  assign retry_cnt  = '0;
`endif

  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign lost_sticky = sticky_q;
  assign loss_cnt    = loss_cnt_q;

endmodule
